find_multi_blobs: RTL
=====================

FIND_MULTI_BLOBS -- requirements
Module: find_multi_blobs

Interface
REQ-001 Parameter MAX_BLOBS, default 8: number of blob tracking slots (1..16).
REQ-002 Parameter CW, default 16: coordinate width of H_CNT/V_CNT and all coordinate outputs.
REQ-003 Parameter AW, default 20: pixel-area accumulator width.
REQ-004 Parameter MIN_AREA, default 4: minimum area for a blob to be reported.
REQ-005 CLK  in  1  pixel clock; all state changes on rising edge.
REQ-006 RST_N  in  1  asynchronous active-low reset.
REQ-007 VGA_HS  in  1  horizontal sync; its falling edge marks a new line.
REQ-008 VGA_VS  in  1  vertical sync; its rising edge marks end of frame.
REQ-009 BINARY_FLAG  in  1  current pixel is foreground.
REQ-010 H_CNT, V_CNT  in  CW each  current pixel coordinates.
REQ-011 BLOB_VALID  out  1  a blob record is presented.
REQ-012 BLOB_READY  in  1  consumer accepts the record.
REQ-013 BLOB_H, BLOB_V  out  CW each  blob bounding-box centre.
REQ-014 BLOB_AREA  out  AW  foreground pixel count of the blob.
REQ-015 BLOB_LAST  out  1  record is the last one of the frame.
REQ-016 BLOB_COUNT  out  5  number of reportable blobs in the last completed frame.
REQ-017 OVERFLOW  out  1  sticky per frame: a run was dropped because no slot was free.
REQ-018 FRAME_DROP  out  1  one-cycle pulse: a readout was aborted by a new frame end.

Function
REQ-019 VGA_HS and VGA_VS SHALL each be registered once; edges are detected against the registered copy.
REQ-020 Run detection: a run SHALL open on the first BINARY_FLAG=1 pixel of a line (start = H_CNT) and close on the first BINARY_FLAG=0 pixel or at an HS falling edge (end = last foreground H_CNT, row = V_CNT of the run).
REQ-021 A closed run SHALL be resolved in the following cycle. All slots are compared in parallel; a slot matches if valid, v_max >= row-1, run_end >= h_min-1 and run_start <= h_max+1 (8-connected against the bounding box).
REQ-022 On a match, the lowest-index matching slot SHALL widen h_min/h_max, set v_max = row, and add (end-start+1) to area, saturating at 2^AW-1.
REQ-023 With no match, the lowest-index free slot SHALL be allocated with h_min=start, h_max=end, v_min=v_max=row, area=length. With no free slot, the run is discarded and OVERFLOW set.
REQ-024 Slots are never merged. A U-shaped object may occupy two slots; this is accepted behaviour.
REQ-025 On a VS rising edge, the working slots SHALL be copied to a report bank in the same cycle and then cleared. OVERFLOW is copied to its output and cleared. A run closing in the same cycle is applied before the copy.
REQ-026 BLOB_COUNT SHALL update one cycle after the VS edge to the number of banked slots with area >= MIN_AREA.
REQ-027 Readout FSM states: IDLE, SCAN, PRESENT.
- IDLE -> SCAN on VS rising edge.
- SCAN advances one slot index per cycle; it goes to PRESENT on a reportable slot, or to IDLE after index MAX_BLOBS-1.
- PRESENT holds all outputs stable with BLOB_VALID=1 until BLOB_READY=1, then returns to SCAN at the next index.
REQ-028 BLOB_H = (h_min+h_max)>>1 and BLOB_V = (v_min+v_max)>>1, computed at CW+1 bits before the shift (no wrap).
REQ-029 BLOB_LAST SHALL be 1 only on the record with the highest reportable index. A frame with zero reportable blobs produces no records.
REQ-030 A VS rising edge in SCAN or PRESENT SHALL pulse FRAME_DROP, deassert BLOB_VALID, rebank, and restart SCAN at index 0.
REQ-031 BLOB_VALID SHALL not depend combinationally on BLOB_READY.

Reset
REQ-032 RST_N low SHALL asynchronously clear all slots, the report bank, and the open run, and return the FSM to IDLE.
REQ-033 While RST_N is low, BLOB_VALID, BLOB_H, BLOB_V, BLOB_AREA, BLOB_LAST, BLOB_COUNT, OVERFLOW and FRAME_DROP SHALL be 0.
REQ-034 Reset deasserted mid-frame SHALL begin tracking from the next pixel; the partial frame is reported at the next VS edge.

Verification
REQ-035 3x3 square at H 10..12, V 20..22, READY=1 -> one record: H=11, V=21, AREA=9, LAST=1, BLOB_COUNT=1.
REQ-036 Two squares (H 10..12 and H 100..103, V 5..8) -> two records in slot order: (11,6,12) and (101,6,16); LAST only on the second.
REQ-037 MAX_BLOBS+1 isolated 2x2 squares -> MAX_BLOBS records, OVERFLOW=1; next empty frame -> OVERFLOW=0, BLOB_COUNT=0, no records.
REQ-038 Single-pixel dot (area 1 < MIN_AREA) -> BLOB_COUNT=0, no VALID. Diagonal pixels (5,5),(6,6) -> same slot.
REQ-039 READY held 0, then VS edge during PRESENT -> FRAME_DROP pulse for one cycle, new frame's records presented.
REQ-040 RST_N pulsed low while BLOB_VALID=1 -> all outputs 0 immediately; no stale record after release.

Source files
------------

// File: rtl/find_multi_blobs.sv
// -----------------------------------------------------------------------------
// find_multi_blobs
//
// Tracks up to MAX_BLOBS foreground blobs in a binarised video stream and
// reports their bounding-box centre and pixel area after each frame.
//
// Horizontal runs of foreground pixels are detected on the fly. Each closed
// run is merged into the first tracking slot whose bounding box it touches
// (8-connected) or allocated to a free slot. At the end of a frame the slots
// are banked and a small FSM streams the reportable ones out over a
// valid/ready handshake.
//
// Ports
//   CLK, RST_N       pixel clock, asynchronous active-low reset
//   VGA_HS, VGA_VS   syncs: HS falling edge = new line, VS rising edge = frame end
//   BINARY_FLAG      current pixel is foreground
//   H_CNT, V_CNT     current pixel coordinates
//   BLOB_VALID/READY record handshake
//   BLOB_H, BLOB_V   bounding-box centre of the presented blob
//   BLOB_AREA        foreground pixel count of the presented blob
//   BLOB_LAST        presented record is the last one of the frame
//   BLOB_COUNT       reportable blobs in the last completed frame
//   OVERFLOW         last completed frame dropped a run for lack of a slot
//   FRAME_DROP       one-cycle pulse: a readout was cut short by a new frame
// -----------------------------------------------------------------------------
module find_multi_blobs #(
  parameter int MAX_BLOBS = 8,
  parameter int CW        = 16,
  parameter int AW        = 20,
  parameter int MIN_AREA  = 4
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          VGA_HS,
  input  logic          VGA_VS,
  input  logic          BINARY_FLAG,
  input  logic [CW-1:0] H_CNT,
  input  logic [CW-1:0] V_CNT,
  output logic          BLOB_VALID,
  input  logic          BLOB_READY,
  output logic [CW-1:0] BLOB_H,
  output logic [CW-1:0] BLOB_V,
  output logic [AW-1:0] BLOB_AREA,
  output logic          BLOB_LAST,
  output logic [4:0]    BLOB_COUNT,
  output logic          OVERFLOW,
  output logic          FRAME_DROP
);

  localparam int            IW         = (MAX_BLOBS > 1) ? $clog2(MAX_BLOBS) : 1;
  localparam int            SW         = AW + 1;
  localparam logic [IW-1:0] LAST_IDX   = IW'(MAX_BLOBS - 1);
  localparam logic [CW:0]   ONE_C      = {{CW{1'b0}}, 1'b1};
  localparam logic [AW-1:0] AREA_MAX   = '1;
  localparam logic [AW-1:0] MIN_AREA_C = AW'(MIN_AREA);

  typedef struct packed {
    logic          valid;
    logic [CW-1:0] h_min;
    logic [CW-1:0] h_max;
    logic [CW-1:0] v_min;
    logic [CW-1:0] v_max;
    logic [AW-1:0] area;
  } slot_t;

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_PRESENT} state_t;

  // ---------------------------------------------------------------------------
  // Sync edge detection and run detection
  // ---------------------------------------------------------------------------
  logic          hs_q, vs_q;
  logic          hs_fall, vs_rise;
  logic          run_open;
  logic [CW-1:0] run_start, run_end, run_row;
  logic          close_now;
  logic          pend_valid;
  logic [CW-1:0] pend_start, pend_end, pend_row;

  assign hs_fall   = hs_q & ~VGA_HS;
  assign vs_rise   = ~vs_q & VGA_VS;
  // A run closes on the first background pixel or when the line ends.
  assign close_now = run_open & (hs_fall | ~BINARY_FLAG);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours, independent of block order.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      hs_q       <= 1'b0;
      vs_q       <= 1'b0;
      run_open   <= 1'b0;
      run_start  <= '0;
      run_end    <= '0;
      run_row    <= '0;
      pend_valid <= 1'b0;
      pend_start <= '0;
      pend_end   <= '0;
      pend_row   <= '0;
    end else begin
      hs_q       <= VGA_HS;
      vs_q       <= VGA_VS;
      pend_valid <= close_now;
      if (close_now) begin
        pend_start <= run_start;
        pend_end   <= run_end;
        pend_row   <= run_row;
      end
      if (hs_fall) begin
        run_open <= 1'b0;
      end else if (BINARY_FLAG) begin
        if (!run_open) begin
          run_open  <= 1'b1;
          run_start <= H_CNT;
          run_row   <= V_CNT;
        end
        run_end <= H_CNT;
      end else begin
        run_open <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Run resolution against the working slots
  // ---------------------------------------------------------------------------
  slot_t                slots    [MAX_BLOBS];
  slot_t                slot_nxt [MAX_BLOBS];
  slot_t                bank     [MAX_BLOBS];
  logic                 ovf_work, ovf_nxt;
  logic [MAX_BLOBS-1:0] match_vec, free_vec;
  logic                 hit, grab;
  logic [IW-1:0]        hit_idx, grab_idx;
  logic [CW:0]          run_len;
  logic [SW-1:0]        area_sum;

  // Comparisons are done one bit wider so row-1 / h_min-1 / h_max+1 never wrap.
  // NOTE: every combinational output gets a default before any branch, so no
  // path leaves a variable unassigned and no latch is inferred.
  always_comb begin
    match_vec = '0;
    free_vec  = '0;
    for (int i = 0; i < MAX_BLOBS; i++) begin
      free_vec[i]  = ~slots[i].valid;
      match_vec[i] = slots[i].valid &&
                     ({1'b0, slots[i].v_max} + ONE_C >= {1'b0, pend_row}) &&
                     ({1'b0, pend_end} + ONE_C >= {1'b0, slots[i].h_min}) &&
                     ({1'b0, pend_start} <= {1'b0, slots[i].h_max} + ONE_C);
    end
  end

  // Descending scan so the lowest matching / free index wins.
  always_comb begin
    hit      = 1'b0;
    grab     = 1'b0;
    hit_idx  = '0;
    grab_idx = '0;
    for (int i = MAX_BLOBS - 1; i >= 0; i--) begin
      if (match_vec[i]) begin
        hit     = 1'b1;
        hit_idx = IW'(i);
      end
      if (free_vec[i]) begin
        grab     = 1'b1;
        grab_idx = IW'(i);
      end
    end
  end

  assign run_len  = {1'b0, pend_end} - {1'b0, pend_start} + ONE_C;
  assign area_sum = {1'b0, slots[hit_idx].area} + SW'(run_len);

  always_comb begin
    slot_nxt = slots;
    ovf_nxt  = ovf_work;
    if (pend_valid) begin
      if (hit) begin
        if (pend_start < slots[hit_idx].h_min) slot_nxt[hit_idx].h_min = pend_start;
        if (pend_end > slots[hit_idx].h_max)   slot_nxt[hit_idx].h_max = pend_end;
        slot_nxt[hit_idx].v_max = pend_row;
        slot_nxt[hit_idx].area  = area_sum[AW] ? AREA_MAX : area_sum[AW-1:0];
      end else if (grab) begin
        slot_nxt[grab_idx] = '{valid: 1'b1, h_min: pend_start, h_max: pend_end,
                               v_min: pend_row, v_max: pend_row, area: AW'(run_len)};
      end else begin
        ovf_nxt = 1'b1;
      end
    end
  end

  // Frame end: the bank captures the slots including any run resolved in the
  // same cycle, and the working set starts the new frame empty.
  // NOTE: the slot arrays are reset explicitly because a stale valid bit would
  // be reported as a blob; this is a small register file, not a RAM.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < MAX_BLOBS; i++) begin
        slots[i] <= '0;
        bank[i]  <= '0;
      end
      ovf_work <= 1'b0;
      OVERFLOW <= 1'b0;
    end else if (vs_rise) begin
      bank <= slot_nxt;
      for (int i = 0; i < MAX_BLOBS; i++) slots[i] <= '0;
      OVERFLOW <= ovf_nxt;
      ovf_work <= 1'b0;
    end else begin
      slots    <= slot_nxt;
      ovf_work <= ovf_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Report bank summary and readout FSM
  // ---------------------------------------------------------------------------
  state_t               state, state_nxt;
  logic [IW-1:0]        idx, idx_nxt;
  logic                 drop_nxt, load;
  logic [MAX_BLOBS-1:0] rep_vec;
  logic [4:0]           rep_cnt;
  logic                 more_after;
  logic [CW:0]          h_sum, v_sum;

  always_comb begin
    rep_vec    = '0;
    rep_cnt    = '0;
    more_after = 1'b0;
    for (int i = 0; i < MAX_BLOBS; i++) begin
      rep_vec[i] = bank[i].valid && (bank[i].area >= MIN_AREA_C);
      rep_cnt    = rep_cnt + 5'(rep_vec[i]);
      if (rep_vec[i] && (i > int'(idx))) more_after = 1'b1;
    end
  end

  assign h_sum = {1'b0, bank[idx].h_min} + {1'b0, bank[idx].h_max};
  assign v_sum = {1'b0, bank[idx].v_min} + {1'b0, bank[idx].v_max};

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= S_IDLE;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  // A new frame end always wins over the handshake and restarts the scan.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    drop_nxt  = 1'b0;
    load      = 1'b0;
    if (vs_rise) begin
      drop_nxt  = (state != S_IDLE);
      state_nxt = S_SCAN;
      idx_nxt   = '0;
    end else begin
      case (state)
        S_SCAN: begin
          if (rep_vec[idx]) begin
            load      = 1'b1;
            state_nxt = S_PRESENT;
          end else if (idx == LAST_IDX) begin
            state_nxt = S_IDLE;
          end else begin
            idx_nxt = idx + 1'b1;
          end
        end
        S_PRESENT: begin
          if (BLOB_READY) begin
            if (idx == LAST_IDX) begin
              state_nxt = S_IDLE;
            end else begin
              state_nxt = S_SCAN;
              idx_nxt   = idx + 1'b1;
            end
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Record fields are captured on entry to PRESENT and held until accepted.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      BLOB_H     <= '0;
      BLOB_V     <= '0;
      BLOB_AREA  <= '0;
      BLOB_LAST  <= 1'b0;
      BLOB_COUNT <= '0;
      FRAME_DROP <= 1'b0;
    end else begin
      BLOB_COUNT <= rep_cnt;
      FRAME_DROP <= drop_nxt;
      if (load) begin
        BLOB_H    <= CW'(h_sum >> 1);
        BLOB_V    <= CW'(v_sum >> 1);
        BLOB_AREA <= bank[idx].area;
        BLOB_LAST <= ~more_after;
      end
    end
  end

  assign BLOB_VALID = (state == S_PRESENT);

endmodule
